video_timing_monitor: RTL and testbench

- Sits directly downstream of the test-pattern generator and consumes its hs/vs/vld/rgb stream.
- Measures three quantities and compares them against programmed expected values:
  - line period (clocks between hs rising edges)
  - active pixels per line
  - active lines per frame
- Reports lock status, sticky mismatch flags, latched measurements and a per-frame pixel checksum.
- Used as a self-check on generated video and as a bring-up monitor on real sources.

---
 rtl/video_timing_monitor.sv | 252 +++++++++++++++++++++++++
 tb/tb_video_timing_monitor.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/video_timing_monitor.sv
// Purpose : passive monitor that measures line period, active pixels per line and
//           active lines per frame against expected values; reports lock, sticky errors and a frame checksum.
// Latency : 2 clocks from a sync edge on the pins to meas_*/frame_done/locked/err_*; no backpressure (observe-only).
//
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   hs, vs, vld, rgb              monitored video stream (sync levels, pixel valid, pixel data)
//   exp_h_total/exp_h_act/exp_v_act  programmed expected timing
//   clr_err                       synchronous clear of the sticky error flags
//   locked, frame_done            lock status, one-cycle pulse per frame close
//   meas_h_total/meas_h_act/meas_v_act/frame_sum  last closed line/frame measurements
//   err_h_total/err_h_act/err_v_act  sticky mismatch flags (set only while locked)
module video_timing_monitor #(
    parameter int PW     = 8,
    parameter int H_BITS = 12,
    parameter int V_BITS = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              hs,
    input  logic              vs,
    input  logic              vld,
    input  logic [3*PW-1:0]   rgb,
    input  logic [H_BITS-1:0] exp_h_total,
    input  logic [H_BITS-1:0] exp_h_act,
    input  logic [V_BITS-1:0] exp_v_act,
    input  logic              clr_err,
    output logic              locked,
    output logic              frame_done,
    output logic [H_BITS-1:0] meas_h_total,
    output logic [H_BITS-1:0] meas_h_act,
    output logic [V_BITS-1:0] meas_v_act,
    output logic [31:0]       frame_sum,
    output logic              err_h_total,
    output logic              err_h_act,
    output logic              err_v_act
);

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        SYNC   = 2'd1,
        LOCKED = 2'd2
    } monState_e;

    localparam logic [H_BITS-1:0] H_ONE = H_BITS'(1);
    localparam logic [V_BITS-1:0] V_ONE = V_BITS'(1);

    monState_e         state;
    monState_e         stateNext;

    logic              hsQ;
    logic              hsPrev;
    logic              vsQ;
    logic              vsPrev;
    logic              vldQ;
    logic [3*PW-1:0]   rgbQ;
    logic              hsRise;
    logic              vsRise;

    logic [H_BITS-1:0] hCnt;
    logic [H_BITS-1:0] aCnt;
    logic [V_BITS-1:0] vCnt;
    logic [V_BITS-1:0] vActNew;
    logic [31:0]       sum;
    logic [31:0]       pixVal;

    logic              skipLine;
    logic              frameBad;
    logic              lineCounts;
    logic              lineChecked;
    logic              lineBad;
    logic              hMis;
    logic              aMis;
    logic              vMis;
    logic              setErrHTotal;
    logic              setErrHAct;
    logic              setErrVAct;

    // Pixel data is delayed alongside the syncs so every counter sees vld/rgb
    // in the same cycle as the edge that was detected for it. The previous-value
    // registers start high so a sync already asserted at reset release is ignored.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hsQ    <= 1'b1;
            hsPrev <= 1'b1;
            vsQ    <= 1'b1;
            vsPrev <= 1'b1;
            vldQ   <= 1'b0;
            rgbQ   <= '0;
        end else begin
            hsQ    <= hs;
            hsPrev <= hsQ;
            vsQ    <= vs;
            vsPrev <= vsQ;
            vldQ   <= vld;
            rgbQ   <= rgb;
        end
    end

    assign hsRise = hsQ & ~hsPrev;
    assign vsRise = vsQ & ~vsPrev;

    assign pixVal = 32'(rgbQ[3*PW-1:2*PW]) + 32'(rgbQ[2*PW-1:PW]) + 32'(rgbQ[PW-1:0]);

    // A line closing on the same cycle as a vs rise still belongs to the old frame.
    assign lineCounts = hsRise && (aCnt != '0);
    assign vActNew    = (lineCounts && !(&vCnt)) ? vCnt + V_ONE : vCnt;

    assign hMis = (hCnt != exp_h_total);
    assign aMis = (aCnt != exp_h_act);
    assign vMis = (vActNew != exp_v_act);

    // The first line close after entering SYNC is a partial line and is ignored.
    assign lineChecked = hsRise && ((state == LOCKED) || ((state == SYNC) && !skipLine));
    assign lineBad     = lineChecked && (hMis || aMis);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hCnt <= '0;
            aCnt <= '0;
            vCnt <= '0;
            sum  <= '0;
        end else begin
            if (hsRise) begin
                hCnt <= H_ONE;
            end else if (!(&hCnt)) begin
                hCnt <= hCnt + H_ONE;
            end

            if (hsRise) begin
                aCnt <= {{(H_BITS-1){1'b0}}, vldQ};
            end else if (vldQ && !(&aCnt)) begin
                aCnt <= aCnt + H_ONE;
            end

            if (vsRise) begin
                vCnt <= '0;
            end else begin
                vCnt <= vActNew;
            end

            // A pixel in the vs-rise cycle opens the new frame's checksum.
            if (vsRise) begin
                sum <= vldQ ? pixVal : 32'd0;
            end else if (vldQ) begin
                sum <= sum + pixVal;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= SEARCH;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext    = state;
        setErrHTotal = 1'b0;
        setErrHAct   = 1'b0;
        setErrVAct   = 1'b0;
        case (state)
            SEARCH: begin
                if (vsRise) begin
                    stateNext = SYNC;
                end
            end
            SYNC: begin
                if (vsRise && !frameBad && !lineBad && !vMis) begin
                    stateNext = LOCKED;
                end
            end
            LOCKED: begin
                setErrHTotal = hsRise && hMis;
                setErrHAct   = hsRise && aMis;
                setErrVAct   = vsRise && vMis;
                if (setErrHTotal || setErrHAct || setErrVAct) begin
                    stateNext = SYNC;
                end
            end
            default: begin
                stateNext = SEARCH;
            end
        endcase
    end

    // frameBad remembers any checked line mismatch in the current frame, including
    // one seen while LOCKED, so a frame that lost lock cannot immediately relock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            skipLine <= 1'b0;
            frameBad <= 1'b0;
        end else begin
            if ((state != SYNC) && (stateNext == SYNC)) begin
                skipLine <= 1'b1;
            end else if ((state == SYNC) && hsRise) begin
                skipLine <= 1'b0;
            end

            if (vsRise) begin
                frameBad <= 1'b0;
            end else if (lineBad) begin
                frameBad <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_done   <= 1'b0;
            meas_h_total <= '0;
            meas_h_act   <= '0;
            meas_v_act   <= '0;
            frame_sum    <= '0;
            err_h_total  <= 1'b0;
            err_h_act    <= 1'b0;
            err_v_act    <= 1'b0;
        end else begin
            frame_done <= vsRise;
            if (hsRise) begin
                meas_h_total <= hCnt;
                meas_h_act   <= aCnt;
            end
            if (vsRise) begin
                meas_v_act <= vActNew;
                frame_sum  <= sum;
            end

            // A new mismatch wins over a simultaneous clear.
            if (setErrHTotal) begin
                err_h_total <= 1'b1;
            end else if (clr_err) begin
                err_h_total <= 1'b0;
            end
            if (setErrHAct) begin
                err_h_act <= 1'b1;
            end else if (clr_err) begin
                err_h_act <= 1'b0;
            end
            if (setErrVAct) begin
                err_v_act <= 1'b1;
            end else if (clr_err) begin
                err_v_act <= 1'b0;
            end
        end
    end

    assign locked = (state == LOCKED);

endmodule

// File: tb/tb_video_timing_monitor.sv
// Directed bench for video_timing_monitor: drives a synthetic 20-clock / 15-pixel line stream,
// frames of 10 active lines, with injected timing faults, simultaneous syncs and a mid-line reset.
// Inputs change on the falling edge; outputs are sampled on the falling edge after each rising edge.
module tb_video_timing_monitor;

    logic        clk;
    logic        rst;
    logic        hs;
    logic        vs;
    logic        vld;
    logic [23:0] rgb;
    logic [11:0] exp_h_total;
    logic [11:0] exp_h_act;
    logic [11:0] exp_v_act;
    logic        clr_err;
    logic        locked;
    logic        frame_done;
    logic [11:0] meas_h_total;
    logic [11:0] meas_h_act;
    logic [11:0] meas_v_act;
    logic [31:0] frame_sum;
    logic        err_h_total;
    logic        err_h_act;
    logic        err_v_act;

    int errors;
    int checks;
    int fdTicks;

    // Output snapshots taken after ticks 0..3 of the most recent line.
    logic [31:0] snLock [4];
    logic [31:0] snFd   [4];
    logic [31:0] snEH   [4];
    logic [31:0] snEA   [4];
    logic [31:0] snEV   [4];
    logic [31:0] snHT   [4];
    logic [31:0] snHA   [4];
    logic [31:0] snMV   [4];
    logic [31:0] snSum  [4];

    video_timing_monitor #(.PW(8), .H_BITS(12), .V_BITS(12)) dut (
        .clk          (clk),
        .rst          (rst),
        .hs           (hs),
        .vs           (vs),
        .vld          (vld),
        .rgb          (rgb),
        .exp_h_total  (exp_h_total),
        .exp_h_act    (exp_h_act),
        .exp_v_act    (exp_v_act),
        .clr_err      (clr_err),
        .locked       (locked),
        .frame_done   (frame_done),
        .meas_h_total (meas_h_total),
        .meas_h_act   (meas_h_act),
        .meas_v_act   (meas_v_act),
        .frame_sum    (frame_sum),
        .err_h_total  (err_h_total),
        .err_h_act    (err_h_act),
        .err_v_act    (err_v_act)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    // One line: hs high ticks 0..3, vld on ticks 2..2+nVld-1, vs high for 4 ticks
    // from vsAt (none if negative), clr_err on tick clrAt (none if negative).
    task automatic runLine(input int period, input int nVld, input int vsAt, input int clrAt);
        fdTicks = 0;
        for (int t = 0; t < period; t++) begin
            hs      = (t < 4);
            vs      = (vsAt >= 0) && (t >= vsAt) && (t < vsAt + 4);
            vld     = (t >= 2) && (t < 2 + nVld);
            clr_err = (t == clrAt);
            @(negedge clk);
            if (t < 4) begin
                snLock[t] = 32'(locked);
                snFd[t]   = 32'(frame_done);
                snEH[t]   = 32'(err_h_total);
                snEA[t]   = 32'(err_h_act);
                snEV[t]   = 32'(err_v_act);
                snHT[t]   = 32'(meas_h_total);
                snHA[t]   = 32'(meas_h_act);
                snMV[t]   = 32'(meas_v_act);
                snSum[t]  = frame_sum;
            end
            if (frame_done) fdTicks++;
        end
        clr_err = 1'b0;
    endtask

    task automatic normalLines(input int n);
        for (int i = 0; i < n; i++) runLine(20, 15, -1, -1);
    endtask

    initial begin
        errors      = 0;
        checks      = 0;
        rst         = 1'b1;
        hs          = 1'b0;
        vs          = 1'b0;
        vld         = 1'b0;
        clr_err     = 1'b0;
        rgb         = {8'd1, 8'd2, 8'd3};
        exp_h_total = 12'd20;
        exp_h_act   = 12'd15;
        exp_v_act   = 12'd10;
        repeat (2) @(negedge clk);

        chk("rst.locked",     32'(locked), 0);
        chk("rst.frame_done", 32'(frame_done), 0);
        chk("rst.meas_h_tot", 32'(meas_h_total), 0);
        chk("rst.meas_h_act", 32'(meas_h_act), 0);
        chk("rst.meas_v_act", 32'(meas_v_act), 0);
        chk("rst.frame_sum",  frame_sum, 0);
        chk("rst.errs",       32'({err_h_total, err_h_act, err_v_act}), 0);

        rst = 1'b0;
        repeat (2) @(negedge clk);
        normalLines(2);

        // Frame 1 opens: SEARCH -> SYNC, first frame close covers the two lead-in lines.
        runLine(20, 15, 1, -1);
        chk("f1.meas_h_tot", snHT[1], 20);
        chk("f1.meas_h_act", snHA[1], 15);
        chk("f1.fd_t2",      snFd[2], 1);
        chk("f1.fd_width",   32'(fdTicks), 1);
        chk("f1.meas_v_act", snMV[2], 2);
        chk("f1.frame_sum",  snSum[2], 180);
        chk("f1.lock_t2",    snLock[2], 0);
        normalLines(9);

        // Frame 2 opens: clean frame 1 gives lock two clocks after the vs edge.
        runLine(20, 15, 1, -1);
        chk("f2.lock_t1",    snLock[1], 0);
        chk("f2.lock_t2",    snLock[2], 1);
        chk("f2.meas_v_act", snMV[2], 10);
        chk("f2.frame_sum",  snSum[2], 900);
        chk("f2.fd_width",   32'(fdTicks), 1);
        chk("f2.errs",       {29'd0, snEH[3][0], snEA[3][0], snEV[3][0]}, 0);
        normalLines(3);
        runLine(21, 15, -1, -1);
        runLine(20, 15, -1, -1);
        chk("long.lock_t0",  snLock[0], 1);
        chk("long.lock_t1",  snLock[1], 0);
        chk("long.meas_h",   snHT[1], 21);
        chk("long.err_h_t0", snEH[0], 0);
        chk("long.err_h_t1", snEH[1], 1);
        chk("long.err_a",    snEA[1], 0);
        normalLines(4);

        // Frame 3: frame 2 had a bad line, so no relock yet.
        runLine(20, 15, 1, -1);
        chk("f3.lock_t2",    snLock[2], 0);
        chk("f3.err_h",      snEH[2], 1);
        chk("f3.meas_v_act", snMV[2], 10);
        normalLines(9);

        // Frame 4: clean frame 3 relocks; sticky error survives until cleared.
        runLine(20, 15, 1, -1);
        chk("f4.lock_t2",    snLock[2], 1);
        chk("f4.err_h",      snEH[2], 1);
        runLine(20, 15, -1, 3);
        chk("clr.err_h_t2",  snEH[2], 1);
        chk("clr.err_h_t3",  snEH[3], 0);
        runLine(20, 15, -1, -1);
        runLine(20, 14, -1, -1);
        runLine(20, 15, -1, -1);
        chk("short.meas_a",  snHA[1], 14);
        chk("short.meas_h",  snHT[1], 20);
        chk("short.err_a",   snEA[1], 1);
        chk("short.err_h",   snEH[1], 0);
        chk("short.lock_t1", snLock[1], 0);
        normalLines(5);

        // Frame 5: still in SYNC; frame 6 relocks and carries 11 active lines.
        runLine(20, 15, 1, -1);
        chk("f5.lock_t2",    snLock[2], 0);
        normalLines(9);
        runLine(20, 15, 1, -1);
        chk("f6.lock_t2",    snLock[2], 1);
        chk("f6.err_a",      snEA[2], 1);
        normalLines(10);

        // Frame 7 opens: 11 lines against 10 expected.
        runLine(20, 15, 1, -1);
        chk("f7.meas_v_act", snMV[2], 11);
        chk("f7.frame_sum",  snSum[2], 990);
        chk("f7.err_v_t1",   snEV[1], 0);
        chk("f7.err_v_t2",   snEV[2], 1);
        chk("f7.lock_t1",    snLock[1], 1);
        chk("f7.lock_t2",    snLock[2], 0);
        normalLines(9);

        // Frame 8 opens with hs and vs rising together.
        runLine(20, 15, 0, -1);
        chk("sim.meas_v_act", snMV[1], 10);
        chk("sim.fd_t1",      snFd[1], 1);
        chk("sim.fd_width",   32'(fdTicks), 1);
        chk("sim.frame_sum",  snSum[1], 900);
        chk("sim.lock_t0",    snLock[0], 0);
        chk("sim.lock_t1",    snLock[1], 1);
        normalLines(9);

        // Frame 9: vs rises on a pixel cycle, which belongs to the new frame.
        runLine(20, 15, 2, -1);
        chk("f9.meas_v_act", snMV[3], 10);
        chk("f9.frame_sum",  snSum[3], 900);
        chk("f9.fd_t2",      snFd[2], 0);
        chk("f9.fd_t3",      snFd[3], 1);
        chk("f9.lock_t3",    snLock[3], 1);
        normalLines(2);

        // Mid-line asynchronous reset with syncs held high through release.
        hs = 1'b1;
        vld = 1'b0;
        repeat (4) @(negedge clk);
        hs = 1'b0;
        vld = 1'b1;
        repeat (3) @(negedge clk);
        chk("pre_rst.locked", 32'(locked), 1);
        #3;
        rst = 1'b1;
        hs  = 1'b1;
        vs  = 1'b1;
        vld = 1'b0;
        #1;
        chk("arst.locked",     32'(locked), 0);
        chk("arst.err_a",      32'(err_h_act), 0);
        chk("arst.err_v",      32'(err_v_act), 0);
        chk("arst.meas_h_tot", 32'(meas_h_total), 0);
        chk("arst.meas_h_act", 32'(meas_h_act), 0);
        chk("arst.meas_v_act", 32'(meas_v_act), 0);
        chk("arst.frame_sum",  frame_sum, 0);
        chk("arst.frame_done", 32'(frame_done), 0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rel.frame_done", 32'(frame_done), 0);
            chk("rel.meas_h_tot", 32'(meas_h_total), 0);
        end
        hs = 1'b0;
        vs = 1'b0;
        @(negedge clk);

        // Relock needs SEARCH -> SYNC -> LOCKED across two vs edges.
        runLine(20, 15, 1, -1);
        chk("ra.lock_t2",    snLock[2], 0);
        chk("ra.fd_t2",      snFd[2], 1);
        chk("ra.meas_v_act", snMV[2], 0);
        chk("ra.frame_sum",  snSum[2], 0);
        normalLines(9);
        runLine(20, 15, 1, -1);
        chk("rb.lock_t1",    snLock[1], 0);
        chk("rb.lock_t2",    snLock[2], 1);
        chk("rb.meas_v_act", snMV[2], 10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
